spi_loader: RTL

SPI_LOADER -- requirements
Module: spi_loader

---
 rtl/spi_loader.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/spi_loader.sv
// spi_loader: host-command to serial-loader bridge that shifts instruction/data words into a processor and supervises runs.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   - host command handshake (ready only while idle)
//   cmd_type              - 00 load instr, 01 load data, 10 run, 11 reserved
//   cmd_addr, cmd_data    - cache address and word for load commands
//   sel_out               - 00 idle, 01 instr select, 10 data select, 11 run
//   mosi_out              - serial frame {data, addr}, LSB first
//   done_in               - processor done flag
//   run_done              - one-cycle pulse when a run completes
//   err_out               - sticky error (reserved command or run timeout)
// Optional: define SPI_LOADER_TIMEOUT_EN to build the run-wait watchdog.
module spi_loader #(
    parameter int GAP_CYCLES  = 1,
    parameter int RUN_TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_type,
    input  logic [3:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic [1:0] sel_out,
    output logic       mosi_out,
    input  logic       done_in,
    output logic       run_done,
    output logic       err_out
);
    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] SHIFT       = 3'd1;
    localparam logic [2:0] GAP         = 3'd2;
    localparam logic [2:0] RUN_WAIT_LO = 3'd3;
    localparam logic [2:0] RUN_WAIT_HI = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [11:0] frame_q, frame_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d, bit_nxt;
    logic [2:0]  gap_cnt_q, gap_cnt_d;
    logic [1:0]  sel_q, sel_d;
    logic        mosi_q, mosi_d;
    logic        run_done_q, run_done_d;
    logic        err_q, err_d;
    logic        rdy_q, rdy_d;
    logic        accept;
    logic        wd_hit;

    assign accept = cmd_valid & rdy_q;

`ifdef SPI_LOADER_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
    assign wd_hit = wd_q == 16'(RUN_TIMEOUT - 1);
`else
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        sel_d      = sel_q;
        mosi_d     = 1'b0;
        run_done_d = 1'b0;
        err_d      = err_q;
        bit_nxt    = bit_cnt_q + 4'd1;
`ifdef SPI_LOADER_TIMEOUT_EN
        wd_d       = wd_q + 16'd1;
`endif
        case (state_q)
            IDLE: begin
                sel_d = 2'b00;
                if (accept) begin
                    if (!cmd_type[1]) begin
                        // Outputs are registered, so bit 0 is presented on the first SHIFT cycle.
                        frame_d   = {cmd_data, cmd_addr};
                        bit_cnt_d = 4'd0;
                        sel_d     = cmd_type[0] ? 2'b10 : 2'b01;
                        mosi_d    = cmd_addr[0];
                        state_d   = SHIFT;
                    end else if (!cmd_type[0]) begin
                        sel_d   = 2'b11;
                        state_d = RUN_WAIT_LO;
`ifdef SPI_LOADER_TIMEOUT_EN
                        wd_d    = 16'd0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (bit_cnt_q == 4'd11) begin
                    sel_d     = 2'b00;
                    gap_cnt_d = 3'd0;
                    state_d   = GAP;
                end else begin
                    bit_cnt_d = bit_nxt;
                    mosi_d    = frame_q[bit_nxt];
                end
            end
            GAP: begin
                sel_d = 2'b00;
                if (gap_cnt_q == 3'(GAP_CYCLES - 1))
                    state_d = IDLE;
                else
                    gap_cnt_d = gap_cnt_q + 3'd1;
            end
            RUN_WAIT_LO: begin
                if (!done_in) begin
                    state_d = RUN_WAIT_HI;
`ifdef SPI_LOADER_TIMEOUT_EN
                    wd_d    = 16'd0;
`endif
                end else if (wd_hit) begin
                    sel_d   = 2'b00;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            RUN_WAIT_HI: begin
                if (done_in) begin
                    sel_d      = 2'b00;
                    run_done_d = 1'b1;
                    state_d    = IDLE;
                end else if (wd_hit) begin
                    sel_d   = 2'b00;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                sel_d   = 2'b00;
                state_d = IDLE;
            end
        endcase
        // Registered ready stays low through reset and rises on the first edge after release.
        rdy_d = state_d == IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            sel_q      <= 2'b00;
            mosi_q     <= 1'b0;
            run_done_q <= 1'b0;
            err_q      <= 1'b0;
            rdy_q      <= 1'b0;
`ifdef SPI_LOADER_TIMEOUT_EN
            wd_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            sel_q      <= sel_d;
            mosi_q     <= mosi_d;
            run_done_q <= run_done_d;
            err_q      <= err_d;
            rdy_q      <= rdy_d;
`ifdef SPI_LOADER_TIMEOUT_EN
            wd_q       <= wd_d;
`endif
        end
    end

    assign cmd_ready = rdy_q;
    assign sel_out   = sel_q;
    assign mosi_out  = mosi_q;
    assign run_done  = run_done_q;
    assign err_out   = err_q;
endmodule
